// File: rtl/mic_rx_pkg.sv
// Shared constants and FSM state type for the I2S microphone receiver.
package mic_rx_pkg;

  localparam int SLOT_BITS  = 32;                  // SCK periods per L or R slot
  localparam int FRAME_BITS = 64;                  // SCK periods per L+R frame
  localparam int SYNC_LAT   = 2;                   // flops in the mic_sd synchroniser
  localparam int BIT_W      = $clog2(FRAME_BITS);  // width of the frame bit counter
  localparam int SLOT_W     = $clog2(SLOT_BITS);   // width of the in-slot bit index

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/mic_i2s_line.sv
// One I2S data line: synchronises mic_sd and shifts the Left and Right
// slot bits into their own registers, MSB first, at the capture strobe.
module mic_i2s_line
  import mic_rx_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_stb,
  input  logic [BIT_W-1:0]    bit_cnt,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data
);

  logic [SYNC_LAT-1:0] sync_q, sync_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic [SLOT_W-1:0]   slot_idx;
  logic                capture;
  logic                sd_sync;

  // Next-state for the synchroniser and the slot shift registers.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
    sync_d   = {sync_q[SYNC_LAT-2:0], sd};
    sd_sync  = sync_q[SYNC_LAT-1];
    slot_idx = bit_cnt[SLOT_W-1:0];
    capture  = sample_stb && (slot_idx >= SLOT_W'(1)) && (slot_idx <= SLOT_W'(SAMPLE_W));
    left_d   = left_q;
    right_d  = right_q;
    if (!enable) begin
      // A partial frame is thrown away; the next frame starts from clean registers.
      left_d  = '0;
      right_d = '0;
    end else if (capture) begin
      if (bit_cnt[BIT_W-1]) begin
        right_d = {right_q[SAMPLE_W-2:0], sd_sync};
      end else begin
        left_d  = {left_q[SAMPLE_W-2:0], sd_sync};
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      sync_q  <= sync_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left_data  = left_q;
  assign right_data = right_q;

endmodule

// File: rtl/mic_i2s_rx.sv
// Multi-line I2S microphone receiver: generates mic_sck/mic_ws, captures
// 2*NUM_LINES samples per frame and drains them as a valid/ready stream.
// Optional feature: define MIC_RX_OVR_CNT_EN to add the saturating
// 16-bit ovr_cnt output counting dropped frames.
module mic_i2s_rx
  import mic_rx_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int SAMPLE_W  = 24,
  parameter int SCK_DIV   = 30
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_LINES-1:0]             mic_sd,
  output logic                             mic_sck,
  output logic                             mic_ws,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SAMPLE_W-1:0]              out_data,
  output logic [$clog2(2*NUM_LINES)-1:0]   out_ch,
  output logic                             out_last,
  output logic                             overrun
`ifdef MIC_RX_OVR_CNT_EN
  ,
  output logic [15:0]                      ovr_cnt
`endif
);

  localparam int NUM_CH = 2 * NUM_LINES;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int DIV_W  = $clog2(SCK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(SCK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(SCK_DIV / 2 + SYNC_LAT);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             mic_sck_q, mic_sck_d;
  logic             mic_ws_q, mic_ws_d;
  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d, ch_next;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             overrun_q, overrun_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] cap;

  logic wrap;
  logic frame_done;
  logic sample_stb;

  assign wrap       = enable && (div_cnt_q == DIV_LAST);
  assign frame_done = wrap && (bit_cnt_q == BIT_LAST);
  assign sample_stb = enable && (div_cnt_q == DIV_SAMPLE);

  // Per-line capture; channel 2*g is the Left mic, 2*g+1 the Right mic.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    mic_i2s_line #(
      .SAMPLE_W (SAMPLE_W)
    ) u_line (
      .clk_in     (clk_in),
      .rst        (rst),
      .enable     (enable),
      .sample_stb (sample_stb),
      .bit_cnt    (bit_cnt_q),
      .sd         (mic_sd[g]),
      .left_data  (cap[2*g]),
      .right_data (cap[2*g+1])
    );
  end

  // Clock divider, frame bit counter and the registered SCK/WS they imply.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bit_cnt_d = bit_cnt_q;
    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (wrap) begin
      div_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end
    // Decoding from the next count makes the flops line up with div_cnt_q.
    mic_sck_d = (div_cnt_d >= DIV_HALF);
    mic_ws_d  = bit_cnt_d[BIT_W-1];
  end

  // Holding buffer and stream FSM: load on frame_done when idle, drop while sending.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    ch_d      = ch_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = 1'b0;
    ch_next   = ch_q + CH_W'(1);
    case (state_q)
      IDLE: begin
        if (frame_done) begin
          hold_d  = cap;
          state_d = SEND;
          ch_d    = '0;
          data_d  = cap[0];
          last_d  = (CH_LAST == '0);
        end
      end
      SEND: begin
        // The buffer counts as full through the final handshake cycle.
        overrun_d = frame_done;
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            ch_d    = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            ch_d   = ch_next;
            data_d = hold_q[ch_next];
            last_d = (ch_next == CH_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      mic_sck_q <= 1'b0;
      mic_ws_q  <= 1'b0;
      state_q   <= IDLE;
      ch_q      <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      mic_sck_q <= mic_sck_d;
      mic_ws_q  <= mic_ws_d;
      state_q   <= state_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  // Sample storage for the frame being drained.
  always_ff @(posedge clk_in) begin
    // NOTE: the buffer has no reset; it is only read while SEND, after a full load.
    hold_q <= hold_d;
  end

`ifdef MIC_RX_OVR_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating count of dropped frames.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

  assign mic_sck   = mic_sck_q;
  assign mic_ws    = mic_ws_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_last  = last_q;
  assign overrun   = overrun_q;

endmodule
